// File: rtl/osd_pkg.sv
// Shared constants, control codes and sequencer states for the OSD text writer.
// The text window is 32x8 cells, so a cell address fits exactly in 8 bits.
package osd_pkg;

    localparam int WINDOW_W = 32;
    localparam int WINDOW_H = 8;
    localparam int LOG2TXT  = 8;
    localparam logic [7:0] BLANK = 8'h20;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] FF = 8'h0C;
    localparam logic [7:0] SO = 8'h0E;
    localparam logic [7:0] SI = 8'h0F;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCR_RD,
        SCR_WR,
        SCR_FILL
    } state_t;

    // Printable codes are 0x20..0x7F; bit 7 is reserved for the invert attribute.
    function automatic logic is_printable(input logic [7:0] code);
        return (code[7] == 1'b0) && (code >= 8'h20);
    endfunction

endpackage

// File: rtl/osd_cursor.sv
// Cursor position counters for the OSD text window.
// scroll_req flags a move that would fall off the bottom row; the cursor then stays on the last row.
module osd_cursor #(
    parameter int WINDOW_W = osd_pkg::WINDOW_W,
    parameter int WINDOW_H = osd_pkg::WINDOW_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       cr,
    input  logic       lf,
    input  logic       bs,
    input  logic       home,
    output logic [4:0] x,
    output logic [2:0] y,
    output logic       scroll_req
);

    localparam logic [4:0] X_LAST = 5'(WINDOW_W - 1);
    localparam logic [2:0] Y_LAST = 3'(WINDOW_H - 1);

    logic [4:0] x_reg, x_next;
    logic [2:0] y_reg, y_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

    always_comb begin
        x_next     = x_reg;
        y_next     = y_reg;
        scroll_req = 1'b0;
        if (home) begin
            x_next = '0;
            y_next = '0;
        end else if (advance) begin
            if (x_reg == X_LAST) begin
                x_next = '0;
                if (y_reg == Y_LAST) begin
                    scroll_req = 1'b1;
                end else begin
                    y_next = y_reg + 3'd1;
                end
            end else begin
                x_next = x_reg + 5'd1;
            end
        end else if (cr) begin
            x_next = '0;
        end else if (lf) begin
            if (y_reg == Y_LAST) begin
                scroll_req = 1'b1;
            end else begin
                y_next = y_reg + 3'd1;
            end
        end else if (bs) begin
            // Backspace stops at column 0; it never reaches back into the previous row.
            if (x_reg != '0) begin
                x_next = x_reg - 5'd1;
            end
        end
    end

    assign x = x_reg;
    assign y = y_reg;

endmodule

// File: rtl/osd_textwriter.sv
// Character-stream OSD text writer: decodes host codes into text-buffer writes,
// and runs whole-buffer clear and one-row scroll sequences with a shared cell counter.
module osd_textwriter #(
    parameter int         WINDOW_W = osd_pkg::WINDOW_W,
    parameter int         WINDOW_H = osd_pkg::WINDOW_H,
    parameter logic [7:0] BLANK    = osd_pkg::BLANK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [7:0] address,
    output logic [7:0] data,
    output logic       wren,
    output logic       rden,
    input  logic [7:0] q,
    output logic [4:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic       busy
);

    import osd_pkg::*;

    localparam logic [7:0] LAST_CELL   = 8'(WINDOW_W * WINDOW_H - 1);
    localparam logic [7:0] SCROLL_LAST = 8'(WINDOW_W * (WINDOW_H - 1) - 1);
    localparam logic [7:0] ROW_STRIDE  = 8'(WINDOW_W);

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       inv_reg, inv_next;
    logic [7:0] address_reg, address_next;
    logic [7:0] data_reg, data_next;
    logic       wr_active, rd_active;

    logic cur_advance, cur_cr, cur_lf, cur_bs, cur_home, scroll_req;

    osd_cursor #(
        .WINDOW_W(WINDOW_W),
        .WINDOW_H(WINDOW_H)
    ) u_cursor (
        .clk       (clk),
        .reset     (reset),
        .advance   (cur_advance),
        .cr        (cur_cr),
        .lf        (cur_lf),
        .bs        (cur_bs),
        .home      (cur_home),
        .x         (cursor_x),
        .y         (cursor_y),
        .scroll_req(scroll_req)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            inv_reg     <= 1'b0;
            address_reg <= '0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            inv_reg     <= inv_next;
            address_reg <= address_next;
            data_reg    <= data_next;
        end
    end

    // Address and data default to their registered values so the bus holds between accesses.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        inv_next     = inv_reg;
        address_next = address_reg;
        data_next    = data_reg;
        wr_active    = 1'b0;
        rd_active    = 1'b0;
        cur_advance  = 1'b0;
        cur_cr       = 1'b0;
        cur_lf       = 1'b0;
        cur_bs       = 1'b0;
        cur_home     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (char_valid) begin
                    if (is_printable(char_in)) begin
                        wr_active    = 1'b1;
                        address_next = 8'(int'(cursor_y) * WINDOW_W + int'(cursor_x));
                        data_next    = {inv_reg, char_in[6:0]};
                        cur_advance  = 1'b1;
                    end else begin
                        unique case (char_in)
                            CR: cur_cr = 1'b1;
                            LF: cur_lf = 1'b1;
                            BS: cur_bs = 1'b1;
                            SO: inv_next = 1'b1;
                            SI: inv_next = 1'b0;
                            FF: begin
                                cur_home   = 1'b1;
                                cnt_next   = '0;
                                state_next = CLEAR;
                            end
                            default: ;
                        endcase
                    end
                    if (scroll_req) begin
                        cnt_next   = '0;
                        state_next = SCR_RD;
                    end
                end
            end

            CLEAR: begin
                wr_active    = 1'b1;
                address_next = cnt_reg;
                data_next    = BLANK;
                cnt_next     = cnt_reg + 8'd1;
                if (cnt_reg == LAST_CELL) begin
                    state_next = IDLE;
                end
            end

            SCR_RD: begin
                rd_active    = 1'b1;
                address_next = cnt_reg + ROW_STRIDE;
                state_next   = SCR_WR;
            end

            // q carries the cell read one row below during the preceding SCR_RD cycle.
            SCR_WR: begin
                wr_active    = 1'b1;
                address_next = cnt_reg;
                data_next    = q;
                cnt_next     = cnt_reg + 8'd1;
                state_next   = (cnt_reg == SCROLL_LAST) ? SCR_FILL : SCR_RD;
            end

            SCR_FILL: begin
                wr_active    = 1'b1;
                address_next = cnt_reg;
                data_next    = BLANK;
                cnt_next     = cnt_reg + 8'd1;
                if (cnt_reg == LAST_CELL) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // Reset forces the bus quiet at once, even while a character is being presented.
    assign wren       = wr_active & ~reset;
    assign rden       = rd_active & ~reset;
    assign address    = reset ? 8'h00 : address_next;
    assign data       = reset ? 8'h00 : data_next;
    assign char_ready = (state_reg == IDLE);
    assign busy       = ~char_ready;

endmodule

// File: tb/tb_osd_textwriter.sv
// Scoreboard bench for osd_textwriter: a cell-level model of the text window predicts every
// buffer write and busy length; a monitor compares DUT writes against the expectation queue.
module tb_osd_textwriter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] address;
    logic [7:0] data;
    logic       wren;
    logic       rden;
    logic [7:0] q;
    logic [4:0] cursor_x;
    logic [2:0] cursor_y;
    logic       busy;

    int total = 0;
    int bad   = 0;

    osd_textwriter dut (
        .clk       (clk),
        .reset     (reset),
        .char_in   (char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .address   (address),
        .data      (data),
        .wren      (wren),
        .rden      (rden),
        .q         (q),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Text buffer RAM with one-cycle registered read.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (wren) mem[address] = data;
        if (rden) q <= mem[address];
    end

    // Reference model state: cursor, invert flag, expected cell contents.
    int         mx, my;
    logic       minv;
    logic [7:0] mbuf [256];
    logic [15:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_write(input int a, input logic [7:0] d);
        exp_q.push_back({8'(a), d});
        mbuf[a] = d;
    endtask

    task automatic model_scroll();
        for (int i = 0; i < 224; i++) expect_write(i, mbuf[i + 32]);
        for (int i = 224; i < 256; i++) expect_write(i, 8'h20);
    endtask

    // Interprets one host code; returns the number of cycles the block should stay busy.
    task automatic model_char(input logic [7:0] c, output int busy_exp);
        busy_exp = 0;
        if (c >= 8'h20 && c <= 8'h7F) begin
            expect_write(my * 32 + mx, {minv, c[6:0]});
            if (mx < 31) mx++;
            else begin
                mx = 0;
                if (my < 7) my++;
                else begin
                    model_scroll();
                    busy_exp = 480;
                end
            end
        end else if (c == 8'h0D) mx = 0;
        else if (c == 8'h0A) begin
            if (my < 7) my++;
            else begin
                model_scroll();
                busy_exp = 480;
            end
        end else if (c == 8'h08) begin
            if (mx > 0) mx--;
        end else if (c == 8'h0E) minv = 1'b1;
        else if (c == 8'h0F) minv = 1'b0;
        else if (c == 8'h0C) begin
            for (int i = 0; i < 256; i++) expect_write(i, 8'h20);
            mx = 0;
            my = 0;
            busy_exp = 256;
        end
    endtask

    // Monitor: every DUT write must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset) begin
            if (wren || rden) check("wr_rd_exclusive", {31'd0, wren & rden}, 32'd0);
            if (wren) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {24'd0, address}, 32'hFFFF_FFFF);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", {24'd0, address}, {24'd0, e[15:8]});
                    check("write_data", {24'd0, data}, {24'd0, e[7:0]});
                end
            end
        end
    end

    // Called at posedge+#1 with the DUT idle; returns at posedge+#1 once it is idle again.
    task automatic send(input logic [7:0] c);
        int busy_exp;
        int cnt;
        model_char(c, busy_exp);
        char_in    = c;
        char_valid = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!char_ready && cnt < 1000);
        check("ready_before_accept", {31'd0, char_ready}, 32'd1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        char_in    = 8'($urandom);
        cnt = 0;
        while (busy === 1'b1 && cnt < 1000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("busy_cycles", cnt, busy_exp);
        check("cursor_x", {27'd0, cursor_x}, mx);
        check("cursor_y", {29'd0, cursor_y}, my);
        $display("char %02h busy=%0d cursor=(%0d,%0d) pending=%0d", c, cnt, cursor_x, cursor_y,
                 exp_q.size());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wren"}, {31'd0, wren}, 32'd0);
        check({tag, "_rden"}, {31'd0, rden}, 32'd0);
        check({tag, "_address"}, {24'd0, address}, 32'd0);
        check({tag, "_data"}, {24'd0, data}, 32'd0);
        check({tag, "_ready"}, {31'd0, char_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_cx"}, {27'd0, cursor_x}, 32'd0);
        check({tag, "_cy"}, {29'd0, cursor_y}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int bc;
        reset      = 1'b1;
        char_valid = 1'b0;
        char_in    = 8'h00;
        mx = 0; my = 0; minv = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'(i);
            mbuf[i] = 8'(i);
        end
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single printable character from home.
        send(8'h41);

        // Invert attribute at (5,2), then back to normal video.
        send(8'h0C);
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h20);
        send(8'h0E);
        send(8'h42);
        send(8'h0F);
        send(8'h42);
        check("inv_cell69", {24'd0, mem[69]}, 32'hC2);
        check("norm_cell70", {24'd0, mem[70]}, 32'h42);

        // Scroll triggered by a write at the last cell over an address pattern.
        send(8'h0C);
        for (int i = 0; i < 7; i++) send(8'h0A);
        for (int i = 0; i < 31; i++) send(8'h61);
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'(i);
            mbuf[i] = 8'(i);
        end
        send(8'h5A);
        check("scroll_cell0", {24'd0, mem[0]}, 32'd32);
        check("scroll_cell100", {24'd0, mem[100]}, 32'd132);
        check("scroll_cell223", {24'd0, mem[223]}, 32'h5A);
        check("scroll_cell240", {24'd0, mem[240]}, 32'h20);

        // Clear, backspace at column 0, ignored bell code.
        send(8'h0C);
        check("clear_cell17", {24'd0, mem[17]}, 32'h20);
        for (int i = 0; i < 3; i++) send(8'h0A);
        send(8'h08);
        send(8'h07);
        send(8'h95);

        // Reset in the middle of a scroll.
        for (int i = 0; i < 4; i++) send(8'h0A);
        model_char(8'h0A, bc);
        char_in    = 8'h0A;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("midscroll");
        exp_q.delete();
        mx = 0; my = 0; minv = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(8'h43);
        send(8'h0C);

        // Randomised character stream.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      send(8'($urandom_range(32, 127)));
            else if (r < 70) send(8'h0A);
            else if (r < 75) send(8'h0D);
            else if (r < 80) send(8'h08);
            else if (r < 84) send(8'h0E);
            else if (r < 88) send(8'h0F);
            else if (r < 90) send(8'h0C);
            else             send(8'($urandom_range(0, 255)));
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        for (int i = 0; i < 256; i++) check("final_buffer", {24'd0, mem[i]}, {24'd0, mbuf[i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/osd_textwriter.md
OSD_TEXTWRITER -- requirements
Module: osd_textwriter

Interface
REQ-001 Parameter WINDOW_W, default 32, meaning text columns per row.
REQ-002 Parameter WINDOW_H, default 8, meaning text rows.
REQ-003 Parameter BLANK, default 8'h20, meaning fill code for clear and scroll.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 char_in  in  8  character or control code from the host.
REQ-007 char_valid  in  1  char_in is valid this cycle.
REQ-008 char_ready  out  1  block accepts char_in this cycle; transfer occurs when char_valid and char_ready are both 1.
REQ-009 address  out  8  text buffer address, row*WINDOW_W+col.
REQ-010 data  out  8  text buffer write data; bit 7 is the invert attribute.
REQ-011 wren  out  1  text buffer write strobe, one cycle per write.
REQ-012 rden  out  1  text buffer read strobe.
REQ-013 q  in  8  text buffer read data, valid exactly one cycle after rden.
REQ-014 cursor_x  out  5  current column.
REQ-015 cursor_y  out  3  current row.
REQ-016 busy  out  1  equals the inverse of char_ready.

Function
REQ-017 States: IDLE, CLEAR, SCR_RD, SCR_WR, SCR_FILL; char_ready=1 only in IDLE.
REQ-018 Code 0x20-0x7F accepted in IDLE: same cycle wren=1, address=cursor, data={inv,char_in[6:0]}; cursor advances next cycle.
REQ-019 Advance: x<31 gives x+1; x=31 gives x=0 and y+1; at y=7 the cursor goes to x=0, y=7 and the block enters SCR_RD.
REQ-020 0x0D (CR): x=0, no write, stay IDLE.
REQ-021 0x0A (LF): if y<7 then y+1 with x unchanged; if y=7 then enter SCR_RD with cursor unchanged.
REQ-022 0x08 (BS): x-1 if x>0, else no-op; never wraps to the previous row; no write.
REQ-023 0x0E sets inv=1 and 0x0F clears inv=0; no write.
REQ-024 0x0C (FF): enter CLEAR; cursor goes to (0,0); inv is unchanged.
REQ-025 All other codes (0x00-0x1F not listed, and 0x80-0xFF) are consumed in one cycle and ignored.
REQ-026 CLEAR: 256 consecutive cycles of wren=1, address=0..255, data=BLANK; then IDLE.
REQ-027 Scroll, for i=0..223: SCR_RD drives rden=1 with address=i+32; the next cycle SCR_WR drives wren=1, address=i, data=q; 448 cycles total.
REQ-028 SCR_FILL: 32 cycles of wren=1, address=224..255, data=BLANK; then IDLE.
REQ-029 Busy duration is exactly 480 cycles for a scroll and 256 for a clear, counted from the cycle after acceptance; char_ready=1 on the following cycle.
REQ-030 wren and rden are never both 1; outside an active write or read, wren=0, rden=0, and address and data hold their last values.
REQ-031 char_valid while busy is not consumed; char_in must be held until accepted.
REQ-032 Address arithmetic is 8-bit modulo; the scroll source never exceeds 255.

Reset
REQ-033 On reset, immediately: state=IDLE, cursor=(0,0), inv=0, address=0, data=0, wren=0, rden=0, char_ready=1.
REQ-034 Reset mid-CLEAR or mid-scroll aborts at once; partial buffer contents remain; no completion writes are issued.
REQ-035 The buffer is not cleared by reset; the host issues FF.

Structure
REQ-036 A shared package osd_pkg holds WINDOW_W, WINDOW_H, LOG2TXT=8, BLANK, the control-code constants (CR, LF, BS, FF, SO, SI) and the state enumeration.
REQ-037 One sub-module osd_cursor holds the x/y counters with advance, CR, LF, BS and home inputs, and a scroll_req output.
REQ-038 The sequencer and the shared 8-bit cell counter stay in osd_textwriter.

Verification
REQ-039 Reset, send 'A'(0x41) -> wren at address 0 with data 0x41, cursor (1,0), char_ready high again next cycle.
REQ-040 Send SO then 'B' at (5,2) -> write at address 69 with data 0xC2; after SI, 'B' writes 0x42.
REQ-041 Fill the buffer with a pattern of each cell's address, cursor (31,7), send 0x5A -> write 0x5A at address 255, then a 480-cycle scroll; cell i=row0..6 holds its old value from i+32, cells 224-255 hold 0x20, cursor (0,7).
REQ-042 Send FF -> 256 writes of 0x20 at addresses 0..255, cursor (0,0), busy exactly 256 cycles.
REQ-043 Send BS at (0,3) -> cursor stays (0,3); send 0x07 -> no write, no state change.
REQ-044 Assert reset at scroll cycle 100 -> outputs take reset values immediately; next 'C' writes address 0.
